// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//   MEMOP_*        : access-type encodings carried on in_MemOp
//   state_e        : access FSM states
//   DefaultTimeout : default BUSY cycle budget before an access is aborted
package mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam int unsigned DefaultTimeout = 16;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage.
//   addr_lo_i    : low two address bits
//   memop_i      : access type
//   load_i       : load requested
//   store_i      : store requested
//   store_data_i : raw store data
//   rdata_i      : read data word from memory
//   fault_o      : misaligned, illegal MemOp, or load+store together
//   be_o         : byte enables (all ones for loads)
//   wdata_o      : lane-replicated store data
//   load_data_o  : extracted and extended load value
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  memop_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        fault_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic        misaligned;
  logic        illegal_op;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    misaligned = 1'b0;
    illegal_op = 1'b0;
    be_o       = 4'hf;
    wdata_o    = store_data_i;
    unique case (memop_i)
      MEMOP_B, MEMOP_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEMOP_H, MEMOP_HU: begin
        misaligned = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{store_data_i[15:0]}};
      end
      MEMOP_W: misaligned = (addr_lo_i != 2'b00);
      default: illegal_op = 1'b1;
    endcase
    // Loads always fetch the whole word; lane selection happens on return.
    if (load_i) be_o = 4'hf;
  end

  assign fault_o = illegal_op | misaligned | (load_i & store_i);

  assign byte_val = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_val = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    unique case (memop_i)
      MEMOP_B:  load_data_o = {{24{byte_val[7]}}, byte_val};
      MEMOP_BU: load_data_o = {24'h0, byte_val};
      MEMOP_H:  load_data_o = {{16{half_val[15]}}, half_val};
      MEMOP_HU: load_data_o = {16'h0, half_val};
      default:  load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX/MEM and MEM/WB.
//   clock, reset          : clock and synchronous active-high reset
//   in_*                  : EX/MEM register contents (held stable while stall is high)
//   stall                 : freeze upstream stages
//   dmem_*                : req/ack data-memory bus (request held until ack or timeout)
//   wb_data/wb_rd/wb_RegWr: MEM/WB register outputs
//   mem_fault             : one-cycle pulse on misaligned/illegal access or bus timeout
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_ALUout,
  input  logic [31:0] in_busB,
  input  logic [2:0]  in_MemOp,
  input  logic [4:0]  in_rd,
  input  logic        in_MemtoReg,
  input  logic        in_RegWr,
  input  logic        in_MemWr,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWr,
  output logic        mem_fault
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_regwr_q, wb_regwr_d;
  logic            fault_q, fault_d;

  logic        access;
  logic        align_fault;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] load_data;

  assign access = in_MemtoReg | in_MemWr;

  mem_align u_align (
    .addr_lo_i    (in_ALUout[1:0]),
    .memop_i      (in_MemOp),
    .load_i       (in_MemtoReg),
    .store_i      (in_MemWr),
    .store_data_i (in_busB),
    .rdata_i      (dmem_rdata),
    .fault_o      (align_fault),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_regwr_d = 1'b0;
    fault_d    = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!access) begin
          wb_data_d  = in_ALUout;
          wb_rd_d    = in_rd;
          wb_regwr_d = in_RegWr;
        end else if (align_fault) begin
          fault_d = 1'b1;
        end else begin
          stall   = 1'b1;
          state_d = StBusy;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = in_MemWr;
          addr_d  = {in_ALUout[31:2], 2'b00};
          be_d    = align_be;
          wdata_d = align_wdata;
        end
      end
      StBusy: begin
        // Ack beats timeout when both land in the same cycle.
        if (dmem_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_data_d  = load_data;
            wb_rd_d    = in_rd;
            wb_regwr_d = in_RegWr;
          end
        end else if (cnt_q == LastCnt) begin
          state_d = StIdle;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regwr_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_regwr_q <= wb_regwr_d;
      fault_q    <= fault_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_RegWr   = wb_regwr_q;
  assign mem_fault  = fault_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result, store data, MemOp, rd and control bits, and performs loads/stores over a req/ack data-memory bus.
- Stalls the upstream pipeline while an access is outstanding, then registers the writeback value into MEM/WB outputs.
- Handles byte/halfword lane steering, load sign/zero extension, misalignment and bus timeout.

Parameters:
- TIMEOUT, 16: max cycles in BUSY waiting for dmem_ack before the access is aborted (must be >= 2).

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_ALUout  in  32  effective address (memory op) or result (non-memory op)
- in_busB  in  32  store data
- in_MemOp  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- in_rd  in  5  destination register
- in_MemtoReg  in  1  load
- in_RegWr  in  1  register write enable
- in_MemWr  in  1  store
- stall  out  1  hold EX/MEM inputs stable and freeze upstream stages
- dmem_req  out  1  access request, held until ack or abort
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address {in_ALUout[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  one-cycle completion pulse; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  read data word
- wb_data  out  32  writeback value (load result or ALU result)
- wb_rd  out  5  writeback register
- wb_RegWr  out  1  writeback enable
- mem_fault  out  1  one-cycle pulse: misaligned/illegal access or timeout

Behaviour:
- Reset: state = IDLE, timeout counter = 0. All registered outputs are 0: wb_*, dmem_*, mem_fault. stall = 0.
- Access: access = in_MemtoReg | in_MemWr. If both are set, the access is treated as a load with a write (illegal; faults).
- Fault check (combinational): H/HU with addr[0] = 1, W with addr[1:0] != 0, MemOp in {011, 110, 111}, or both Mem bits set.
- IDLE, no access: next edge wb_data = in_ALUout, wb_rd = in_rd, wb_RegWr = in_RegWr. Latency 1 cycle, stall = 0.
- IDLE, access, fault: no request issued. Next edge: mem_fault = 1 (one cycle), wb_RegWr = 0. Remain in IDLE, stall = 0.
- IDLE, access, legal:
  - stall = 1 combinationally in this cycle.
  - Next edge: go to BUSY; dmem_req = 1; dmem_addr/we/be/wdata are registered; counter = 0; wb_RegWr = 0 (bubble).
- BUSY:
  - dmem_req and the bus fields stay constant.
  - stall = 1 except in the ack cycle. Upstream inputs are stable for the whole access.
  - Every stalled edge writes wb_RegWr = 0; wb_data and wb_rd hold.
- BUSY, dmem_ack = 1: stall = 0 in this cycle. Next edge:
  - dmem_req = 0, state = IDLE.
  - Load: wb_data = extended load value, wb_rd = in_rd, wb_RegWr = in_RegWr.
  - Store: wb_RegWr = 0.
  - Minimum memory-op latency: 2 stall cycles.
- BUSY, no ack: counter increments.
- Timeout: when counter = TIMEOUT-1 and there is no ack, stall = 0 in that cycle. Next edge: dmem_req = 0, mem_fault = 1, wb_RegWr = 0, state = IDLE.
- Ack in the same cycle as the timeout: ack wins, no fault.
- dmem_ack while in IDLE: ignored.
- Store steering:
  - SB: be = 0001 << addr[1:0], wdata = {4{busB[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{busB[15:0]}}.
  - SW: be = 1111, wdata = busB.
- Load: be = 1111. Byte = rdata >> (8*addr[1:0]), halfword = rdata >> (16*addr[1]). B/H sign-extend, BU/HU zero-extend, W passes through.
- Reset mid-access: synchronous reset dominates. dmem_req drops at that edge; no writeback, no fault.
- rd = 0 is not special-cased here; the register file ignores it.

Decomposition:
- Package mem_pkg:
  - MemOp constants MEMOP_B/H/W/BU/HU.
  - State enum {IDLE, BUSY}.
  - Default TIMEOUT.
- Sub-module mem_align (combinational):
  - Fault detection.
  - Store byte-enable and data steering.
  - Load extraction and extension.
- mem_stage holds the FSM, the timeout counter and the MEM/WB registers.

Test Plan:
- Non-memory op: ALUout = 0x00001234, rd = 5, RegWr = 1 -> next edge wb_data = 0x00001234, wb_rd = 5, wb_RegWr = 1, stall never high.
- LB at 0x103: ack after 3 cycles with rdata = 0x80FF7F01 -> dmem_addr = 0x100, be = 1111, stall high 3 cycles, wb_data = 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH at 0x202 with busB = 0xDEADBEEF:
  - dmem_we = 1, be = 1100, wdata = 0xBEEFBEEF.
  - Immediate next-cycle ack -> stall exactly 2 cycles, wb_RegWr = 0.
- LW at 0x301 -> no dmem_req, mem_fault pulses 1 cycle, wb_RegWr = 0, stall = 0. MemOp = 011 gives the same response.
- TIMEOUT = 4, LW at 0x400 with ack never asserted -> req high 4 cycles, then req = 0, mem_fault = 1, wb_RegWr = 0, pipeline resumes.
- Reset asserted in the second BUSY cycle -> dmem_req = 0 and all outputs 0 at the next edge. A later ack is ignored and no fault is raised.
